// File: rtl/matmul_result_streamer.sv
// matmul_result_streamer
// Waits out the 3x3 multiplier pipeline latency after an operand issue.
// Captures the nine results into a local buffer.
// Streams them row-major over valid/ready with last/row/col sideband.
//
//   state  | meaning
//   IDLE   | no matrix in flight; waiting for an enabled start
//   WAIT   | operands in the multiplier pipeline; counting enabled edges
//   STREAM | buffer captured; presenting elements until (2,2) transfers

module matmul_result_streamer #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           start,
    input  logic [0:2][0:2][DATA_W-1:0]    matmul,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [1:0]                     out_row,
    output logic [1:0]                     out_col,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // The start edge is itself the first enabled edge, hence LATENCY-1.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                         state;
    logic [3:0]                     cnt;
    logic [0:2][0:2][DATA_W-1:0]    data_buf;
    logic                           capture;
    logic                           xfer;

    // Once cnt reaches zero the multiplier outputs are settled and held,
    // so capture does not need enable.
    assign capture = (state == WAIT) && (cnt == 4'd0);
    assign xfer    = out_valid && out_ready;

    // Element mux from the registered indices; rows/cols never reach 3.
    assign out_data = data_buf[out_row][out_col];

    // Result buffer: loaded only on the capture edge, otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_buf <= '0;
        end else if (capture) begin
            data_buf <= matmul;
        end
    end

    // Control FSM: latency tracking, stream indexing and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= 2'd0;
            out_col   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;

            // A start that cannot be accepted is lost; flag it until reset.
            if (start && enable && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start && enable) begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                    end
                end

                WAIT: begin
                    if (capture) begin
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        out_row   <= 2'd0;
                        out_col   <= 2'd0;
                        out_last  <= 1'b0;
                    end else if (enable) begin
                        cnt <= cnt - 4'd1;
                    end
                end

                STREAM: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_row   <= 2'd0;
                            out_col   <= 2'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (out_col == 2'd2) begin
                            out_row  <= out_row + 2'd1;
                            out_col  <= 2'd0;
                            out_last <= 1'b0;
                        end else begin
                            out_col  <= out_col + 2'd1;
                            out_last <= (out_row == 2'd2) && (out_col == 2'd1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Bench for matmul_result_streamer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against
// a queue-based behavioural model.

module tb_matmul_result_streamer;

    localparam int DW  = 16;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [0:2][0:2][DW-1:0] matmul = '0;

    logic [DW-1:0] out_data;
    logic out_valid, out_last, busy, done, overrun;
    logic [1:0] out_row, out_col;

    logic start1 = 1'b0;
    logic [DW-1:0] out_data1;
    logic out_valid1, out_last1, busy1, done1, overrun1;
    logic [1:0] out_row1, out_col1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    matmul_result_streamer #(.DATA_W(DW), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .matmul(matmul), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_row(out_row),
        .out_col(out_col), .busy(busy), .done(done), .overrun(overrun)
    );

    matmul_result_streamer #(.DATA_W(DW), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .enable(enable), .start(start1),
        .matmul(matmul), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(1'b1), .out_last(out_last1), .out_row(out_row1),
        .out_col(out_col1), .busy(busy1), .done(done1), .overrun(overrun1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] d;
        int r;
        int c;
    } elem_t;

    elem_t q[$];
    int m_phase = 0;   // 0 idle, 1 waiting on pipeline, 2 streaming
    int m_seen  = 0;   // enabled edges counted since (and including) the start edge
    bit m_done  = 0;
    bit m_ovr   = 0;

    initial begin
        forever begin
            int ph;
            elem_t e;
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_phase = 0; m_seen = 0; m_done = 0; m_ovr = 0;
            end else begin
                ph = m_phase;
                m_done = 0;
                if (ph != 0 && start && enable) m_ovr = 1;
                if (ph == 0) begin
                    if (start && enable) begin m_phase = 1; m_seen = 1; end
                end else if (ph == 1) begin
                    if (m_seen >= LAT) begin
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++) begin
                                e.d = matmul[r][c]; e.r = r; e.c = c;
                                q.push_back(e);
                            end
                        m_phase = 2;
                    end else if (enable) begin
                        m_seen++;
                    end
                end else begin
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (q.size() == 0) begin m_phase = 0; m_done = 1; end
                    end
                end
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("valid", out_valid, q.size() != 0);
                if (q.size() != 0) begin
                    check("data", out_data, q[0].d);
                    check("row", out_row, q[0].r);
                    check("col", out_col, q[0].c);
                    check("last", out_last, (q[0].r == 2 && q[0].c == 2));
                end
                check("busy", busy, m_phase != 0);
                check("done", done, m_done);
                check("overrun", overrun, m_ovr);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic set_mat(input int base);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                matmul[r][c] = DW'(base + r * 3 + c);
    endtask

    task automatic run_matrix(input int gap, input int exp_lat, input int base,
                              input int bp_val, input bit ovr_start);
        int lat, n, hold, guard;
        logic [DW-1:0] got[9];
        logic lastseen[9];
        bit fired;
        start = 1; @(negedge clk); start = 0;
        if (gap > 0) begin
            enable = 0; repeat (gap) @(negedge clk); enable = 1;
        end
        lat = gap;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        check("latency", lat, exp_lat);
        // Results after capture must not reach the stream.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                matmul[r][c] = DW'($urandom);
        n = 0; hold = 0; guard = 0; fired = 0;
        while (n < 9 && guard < 100) begin
            start = 0;
            if (bp_val != 0 && out_valid && out_data == DW'(bp_val) && hold < 3) begin
                out_ready = 0; hold++;
                check("bp_data", out_data, bp_val);
                check("bp_row", out_row, 1);
                check("bp_col", out_col, 0);
            end else begin
                out_ready = 1;
                if (out_valid) begin got[n] = out_data; lastseen[n] = out_last; n++; end
            end
            if (ovr_start && n == 5 && !fired) begin start = 1; fired = 1; end
            @(negedge clk); guard++;
        end
        start = 0; out_ready = 1;
        check("count", n, 9);
        for (int i = 0; i < 9; i++) begin
            check("seq_data", got[i], base + i);
            check("seq_last", lastseen[i], i == 8);
        end
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("valid_after", out_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", out_data, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_last", out_last, 0);
        check("rst_l1_valid", out_valid1, 0);

        reset = 0; enable = 1; out_ready = 1;

        set_mat(1); run_matrix(0, 3, 1, 0, 0);   // basic
        set_mat(1); run_matrix(2, 5, 1, 0, 0);   // enable gaps
        set_mat(1); run_matrix(0, 3, 1, 4, 0);   // backpressure on element 4
        check("ovr_before", overrun, 0);
        set_mat(1); run_matrix(0, 3, 1, 0, 1);   // second start mid-stream
        check("ovr_set", overrun, 1);
        repeat (10) begin
            @(negedge clk);
            check("no_second_stream", out_valid, 0);
        end
        check("ovr_sticky", overrun, 1);

        // start with enable low in IDLE is ignored
        enable = 0; start = 1; @(negedge clk); start = 0; enable = 1;
        repeat (4) begin
            @(negedge clk);
            check("dis_start_busy", busy, 0);
            check("dis_start_valid", out_valid, 0);
        end

        // asynchronous reset after three transfers
        set_mat(1); start = 1; @(negedge clk); start = 0;
        g = 0;
        while (!(out_valid && out_data == DW'(4)) && g < 30) begin @(negedge clk); g++; end
        check("reached_elem4", out_data, 4);
        #2 reset = 1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        @(negedge clk); reset = 0;
        set_mat(101); run_matrix(0, 3, 101, 0, 0);

        // LATENCY=1 instance: capture on the edge after the start edge
        set_mat(7); start1 = 1; @(negedge clk); start1 = 0;
        check("l1_wait_valid", out_valid1, 0);
        check("l1_wait_busy", busy1, 1);
        @(negedge clk);
        check("l1_valid", out_valid1, 1);
        check("l1_data", out_data1, 7);
        check("l1_row", out_row1, 0);
        check("l1_col", out_col1, 0);
        repeat (12) @(negedge clk);
        check("l1_idle", busy1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    matmul[r][c] = DW'($urandom);
            @(negedge clk);
        end
        start = 0; enable = 1; out_ready = 1;
        repeat (40) @(negedge clk);
        check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1);
    end

endmodule
